bin_to_bcd3: RTL and testbench



---
 rtl/bin_to_bcd3_pkg.sv | 48 ++++
 rtl/bin_to_bcd3_add3.sv | 21 ++
 rtl/bin_to_bcd3.sv | 159 +++++++++++++++
 tb/tb_bin_to_bcd3.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd3_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd3_pkg
//   Shared definitions for the sequential binary-to-BCD converter.
//   - state_e          : converter FSM encoding (IDLE / SHIFT / DONE)
//   - BCD_MAX          : largest value representable in three BCD digits
//   - BCD_DIGITS       : number of BCD output digits
//   - clog2()          : ceiling log2, used to size the iteration counter
//   - reduce_mod1000() : remainder modulo 1000 built from a short chain of
//                        constant compare/subtract stages (no divider)
// -----------------------------------------------------------------------------
package bin_to_bcd3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int BCD_MAX    = 999;
    localparam int BCD_DIGITS = 3;

    // Smallest r such that 2**r >= v (minimum 1 so a counter is never 0 wide).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Restoring-style remainder: subtract 1000*2^k for k = 6..0 whenever it
    // fits. 1000*64 = 64000 covers every 16-bit input, so after the chain the
    // residue is always below 1000 and fits in 10 bits.
    function automatic logic [9:0] reduce_mod1000(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int k = 6; k >= 0; k--) begin
            if (r >= (32'd1000 << k)) begin
                r = r - (32'd1000 << k);
            end
        end
        return r[9:0];
    endfunction

endpackage

// File: rtl/bin_to_bcd3_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble nibble corrector: a digit of 5 or more gets +3
//   so that the following left shift carries correctly into the next digit.
//   Ports:
//     in_i  [3:0]  BCD digit before correction
//     out_o [3:0]  corrected digit
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);

    always_comb begin
        out_o = in_i;
        if (in_i >= 4'd5) begin
            out_o = in_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd3.sv
// -----------------------------------------------------------------------------
// bin_to_bcd3
//   Iterative binary-to-BCD converter (double-dabble, one bit per cycle).
//   Drives the three digit inputs of the multiplexed 7-segment LED driver.
//   Digits and ovf are only updated when a conversion completes, so the
//   display never sees intermediate shift states.
//   Parameters:
//     IN_W      width of bin (4..16)
//     SATURATE  1: inputs above 999 convert as 999; 0: convert modulo 1000.
//               Both modes set ovf for inputs above 999.
//   Ports:
//     clocksource  in   system clock, rising edge
//     reset        in   asynchronous active-high reset
//     start        in   conversion request (accepted in IDLE or DONE)
//     bin          in   unsigned value, captured when start is accepted
//     busy         out  high while shifting
//     done         out  one-cycle pulse, digits valid in the same cycle
//     ovf          out  last completed conversion exceeded 999
//     x0/x1/x2     out  ones / tens / hundreds BCD digits
//   Handshake: start is sampled on a rising edge only while busy=0; a start
//   seen while busy=1 is dropped, not queued. done=1 marks the one cycle in
//   which freshly converted digits first appear; busy and done never overlap.
// -----------------------------------------------------------------------------
module bin_to_bcd3
    import bin_to_bcd3_pkg::*;
#(
    parameter int IN_W     = 10,
    parameter int SATURATE = 1
) (
    input  logic            clocksource,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [3:0]      x0,
    output logic [3:0]      x1,
    output logic [3:0]      x2
);

    localparam int CNT_W = clog2(IN_W + 1);

    state_e           state_q;
    logic [IN_W-1:0]  sr_q;
    logic [11:0]      bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_pend_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [3:0]       x0_q;
    logic [3:0]       x1_q;
    logic [3:0]       x2_q;

    // ---------------------------------------------------------------------
    // Input capture: out-of-range detection and single-cycle reduction
    // ---------------------------------------------------------------------
    logic [31:0]     bin_ext;
    logic            over;
    logic [9:0]      reduced;
    logic [IN_W-1:0] load_val;

    assign bin_ext  = 32'(bin);
    assign over     = (bin_ext > 32'(BCD_MAX));
    assign reduced  = (SATURATE != 0) ? 10'(BCD_MAX) : reduce_mod1000(bin_ext);
    // When over is set the reduced value is < 1000, which always fits in IN_W
    // because over can only be true for IN_W >= 10.
    assign load_val = over ? IN_W'(reduced) : bin;

    // ---------------------------------------------------------------------
    // One double-dabble iteration: correct every digit, then shift
    // {bcd, sr} left by one.
    // ---------------------------------------------------------------------
    logic [11:0]     bcd_adj;
    logic [11:0]     bcd_shift;
    logic [IN_W-1:0] sr_shift;
    logic            unused_carry;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (bcd_q[4*g +: 4]),
            .out_o (bcd_adj[4*g +: 4])
        );
    end

    // Values never exceed 999, so the hundreds digit is at most 4 before its
    // final shift and the bit shifted out of the accumulator is always 0.
    assign bcd_shift    = {bcd_adj[10:0], sr_q[IN_W-1]};
    assign sr_shift     = {sr_q[IN_W-2:0], 1'b0};
    assign unused_carry = bcd_adj[11];

    logic last_iter;
    assign last_iter = (cnt_q == CNT_W'(IN_W - 1));

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clocksource or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            x0_q       <= 4'h0;
            x1_q       <= 4'h0;
            x2_q       <= 4'h0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sr_q       <= load_val;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        ovf_pend_q <= over;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sr_q  <= sr_shift;
                    bcd_q <= bcd_shift;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        // Publish the result on the same edge the last shift
                        // completes, so digits and done appear together.
                        x0_q    <= bcd_shift[3:0];
                        x1_q    <= bcd_shift[7:4];
                        x2_q    <= bcd_shift[11:8];
                        ovf_q   <= ovf_pend_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign x0   = x0_q;
    assign x1   = x1_q;
    assign x2   = x2_q;

endmodule

// File: tb/tb_bin_to_bcd3.sv
module tb_bin_to_bcd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [9:0] bin;

  always #5 clk = ~clk;

  // Two instances share stimulus: one saturating, one modulo-1000.
  logic busy_s, done_s, ovf_s;
  logic [3:0] x0_s, x1_s, x2_s;
  logic busy_m, done_m, ovf_m;
  logic [3:0] x0_m, x1_m, x2_m;

  bin_to_bcd3 #(.IN_W(10), .SATURATE(1)) dut_sat (
    .clocksource (clk),
    .reset       (rst),
    .start       (start),
    .bin         (bin),
    .busy        (busy_s),
    .done        (done_s),
    .ovf         (ovf_s),
    .x0          (x0_s),
    .x1          (x1_s),
    .x2          (x2_s)
  );

  bin_to_bcd3 #(.IN_W(10), .SATURATE(0)) dut_mod (
    .clocksource (clk),
    .reset       (rst),
    .start       (start),
    .bin         (bin),
    .busy        (busy_m),
    .done        (done_m),
    .ovf         (ovf_m),
    .x0          (x0_m),
    .x1          (x1_m),
    .x2          (x2_m)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: {ovf, x2, x1, x0}
  // ---------------------------------------------------------------------------
  logic [12:0] exp_q_sat[$];
  logic [12:0] exp_q_mod[$];
  logic [12:0] held_sat;
  logic [12:0] held_mod;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] res(input logic o, input logic [11:0] d);
    return {o, d};
  endfunction

  // Monitor: pops an expectation on every done, otherwise requires outputs to
  // hold the last expected result.
  always @(negedge clk) begin
    logic [12:0] cur_s;
    logic [12:0] cur_m;
    logic [12:0] e;
    cur_s = {ovf_s, x2_s, x1_s, x0_s};
    cur_m = {ovf_m, x2_m, x1_m, x0_m};
    if (rst) begin
      held_sat = '0;
      held_mod = '0;
    end else begin
      check("busy_done_excl_sat", 32'(busy_s & done_s), 32'd0);
      check("busy_done_excl_mod", 32'(busy_m & done_m), 32'd0);
      if (done_s) begin
        if (exp_q_sat.size() == 0) begin
          check("unexpected_done_sat", 32'd1, 32'd0);
        end else begin
          e = exp_q_sat.pop_front();
          check("result_sat", 32'(cur_s), 32'(e));
          held_sat = e;
        end
      end else begin
        check("hold_sat", 32'(cur_s), 32'(held_sat));
      end
      if (done_m) begin
        if (exp_q_mod.size() == 0) begin
          check("unexpected_done_mod", 32'd1, 32'd0);
        end else begin
          e = exp_q_mod.pop_front();
          check("result_mod", 32'(cur_m), 32'(e));
          held_mod = e;
        end
      end else begin
        check("hold_mod", 32'(cur_m), 32'(held_mod));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge)
  // ---------------------------------------------------------------------------
  task automatic drive_start(input logic [9:0] b, input logic [12:0] e_sat,
                             input logic [12:0] e_mod, input bit push);
    start = 1'b1;
    bin   = b;
    if (push) begin
      exp_q_sat.push_back(e_sat);
      exp_q_mod.push_back(e_mod);
    end
  endtask

  // n0: negedges already seen since the start edge; b0: busy cycles counted.
  task automatic wait_done(input int n0, input int b0, input bit chk_busy);
    int n;
    int b;
    n = n0;
    b = b0;
    while (!done_s && n < 40) begin
      @(negedge clk);
      n++;
      if (busy_s) b++;
    end
    check("latency", 32'(n), 32'd11);
    check("done_together", 32'(done_m), 32'd1);
    if (chk_busy) check("busy_cycles", 32'(b), 32'd10);
  endtask

  task automatic convert(input logic [9:0] b, input logic [12:0] e_sat, input logic [12:0] e_mod);
    @(negedge clk);
    drive_start(b, e_sat, e_mod, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, int'(busy_s), 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy_s), 32'd0);
    check("idle_done", 32'(done_s), 32'd0);
    check("idle_out_sat", 32'({ovf_s, x2_s, x1_s, x0_s}), 32'd0);
    check("idle_out_mod", 32'({ovf_m, x2_m, x1_m, x0_m}), 32'd0);

    // Basic and boundary conversions
    convert(10'd255,  res(1'b0, 12'h255), res(1'b0, 12'h255));
    @(negedge clk);
    check("back_to_idle", 32'({busy_s, done_s}), 32'd0);
    convert(10'd999,  res(1'b0, 12'h999), res(1'b0, 12'h999));
    convert(10'd0,    res(1'b0, 12'h000), res(1'b0, 12'h000));

    // Overflow: saturate vs modulo, then ovf clears
    convert(10'd1023, res(1'b1, 12'h999), res(1'b1, 12'h023));
    convert(10'd7,    res(1'b0, 12'h007), res(1'b0, 12'h007));

    // Start during SHIFT is ignored; start during DONE is accepted
    @(negedge clk);
    drive_start(10'd42, res(1'b0, 12'h042), res(1'b0, 12'h042), 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    drive_start(10'd100, '0, '0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    bin   = 10'd555;
    wait_done(5, 0, 1'b0);
    drive_start(10'd100, res(1'b0, 12'h100), res(1'b0, 12'h100), 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("digits_held_in_shift", 32'({x2_s, x1_s, x0_s}), 32'h042);
    wait_done(1, int'(busy_s), 1'b1);

    // Reset mid-conversion
    convert(10'd123, res(1'b0, 12'h123), res(1'b0, 12'h123));
    @(negedge clk);
    drive_start(10'd500, '0, '0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'({busy_s, busy_m}), 32'd0);
    check("rst_done", 32'({done_s, done_m}), 32'd0);
    check("rst_out_sat", 32'({ovf_s, x2_s, x1_s, x0_s}), 32'd0);
    check("rst_out_mod", 32'({ovf_m, x2_m, x1_m, x0_m}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    convert(10'd7, res(1'b0, 12'h007), res(1'b0, 12'h007));

    repeat (3) @(negedge clk);
    check("sat_queue_empty", 32'(exp_q_sat.size()), 32'd0);
    check("mod_queue_empty", 32'(exp_q_mod.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
